// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_buffered_pkg;

  localparam int DEFAULT_BAUD = 115_200;

  // PARITY stays in the encoding even when the parity bit is not built,
  // so the state width and values do not depend on the build option.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity over one byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte stream handshake between the command FSM (master) and the UART transmitter (slave).
interface uart_tx_buffered_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with a registered occupancy count and a combinational read head.
// Writes while full are ignored; a pop in the same cycle does not make room.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             wr_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == CNT_W'(0));
  assign count   = count_r;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_r];

  // Storage array write; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes from a valid/ready stream are queued in a
// byte FIFO and sent as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = DEFAULT_BAUD,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_buffered_if.slave           in_bus,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_tx_state_t    state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              tx_r;
  logic              overflow_r;
`ifdef UART_TX_PARITY_EN
  logic              parity_r;
`endif

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] head_byte;
  logic       baud_done;

  // The FIFO drops pushes while full on its own; ready only advertises space.
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_bus.valid),
    .wr_data (in_bus.data),
    .pop     (fifo_pop),
    .rd_data (head_byte),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_o)
  );

  assign in_bus.ready = !fifo_full;
  assign fifo_pop     = (state_r == IDLE) && !fifo_empty;
  assign baud_done    = (baud_r == BAUD_LAST);
  assign tx_o         = tx_r;
  assign overflow_o   = overflow_r;
  assign busy_o       = (state_r != IDLE) || !fifo_empty;

  // Sticky overflow flag: set by any push attempt against a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (in_bus.valid && fifo_full) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Transmit FSM with registered line output; the baud counter restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      baud_r    <= BAUD_W'(0);
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          baud_r <= BAUD_W'(0);
          if (!fifo_empty) begin
            shift_r <= head_byte;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(head_byte);
`endif
            state_r <= START;
            tx_r    <= 1'b0;
          end else begin
            tx_r <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            state_r   <= DATA;
            baud_r    <= BAUD_W'(0);
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_r <= BAUD_W'(0);
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
              tx_r    <= parity_r;
`else
              state_r <= STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              // LSB-first: drop the bit just sent and present the next one.
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state_r <= STOP;
            baud_r  <= BAUD_W'(0);
            tx_r    <= 1'b1;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            state_r <= IDLE;
            baud_r  <= BAUD_W'(0);
            tx_r    <= 1'b1;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= BAUD_W'(0);
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (CLKS_PER_BIT = 10, depth 16).
// Define UART_TX_PARITY_EN to exercise the 8E1 build.
module tb_uart_tx_buffered;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx;
  logic       busy;
  logic [4:0] fcount;
  logic       ovf;

  uart_tx_buffered_if bus();

  uart_tx_buffered #(
    .CLK_FREQ_HZ (1000),
    .BAUD_RATE   (100),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_bus       (bus),
    .tx_o         (tx),
    .busy_o       (busy),
    .fifo_count_o (fcount),
    .overflow_o   (ovf)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         rx_bad   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] burst[32];
  logic       model_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Ideal line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    else if (k == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  // Line receiver: decodes frames at mid-bit, independent of DUT internals.
  initial begin : rx_monitor
    int         off;
    int         j;
    logic       active;
    logic       bad;
    logic [7:0] b;
    active = 1'b0; off = 0; bad = 1'b0; b = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1; off = 0; bad = 1'b0; b = 8'h00;
        end
      end else begin
        off++;
        if (off % CPB == CPB / 2) begin
          j = off / CPB;
          if (j == 0) begin
            if (tx !== 1'b0) bad = 1'b1;
          end else if (j <= 8) begin
            b[j-1] = tx;
          end else if (j < FRAME_BITS - 1) begin
            if (tx !== ^b) bad = 1'b1;
          end else begin
            if (tx !== 1'b1) bad = 1'b1;
            rx_q.push_back(b);
            if (bad) rx_bad++;
            active = 1'b0;
          end
        end
      end
    end
  end

  // Push one byte from idle and check the whole waveform cycle by cycle.
  task automatic check_frame(input logic [7:0] b, input string tag);
    @(negedge clk);
    chk({tag, "_idle_before"}, busy, 0);
    bus.valid = 1'b1; bus.data = b;
    @(negedge clk);
    bus.valid = 1'b0;
    chk({tag, "_n1_tx_high"}, tx, 1);
    chk({tag, "_n1_count"}, fcount, 1);
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      @(negedge clk);
      chk($sformatf("%s_bit%0d_cyc%0d", tag, i / CPB, i % CPB), tx, frame_bit(b, i / CPB));
    end
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_tx_after"}, tx, 1);
  endtask

  // One push per cycle from an idle, empty DUT; the model knows only the
  // occupancy rule and that the first byte is popped the cycle after it lands.
  task automatic push_burst(input int n, input string tag);
    int   cnt;
    logic acc;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s_ready_k%0d", tag, k), bus.ready, (cnt != DEPTH));
      chk($sformatf("%s_count_k%0d", tag, k), fcount, cnt);
      bus.valid = 1'b1; bus.data = burst[k];
      acc = (cnt != DEPTH);
      if (acc) exp_q.push_back(burst[k]);
      else model_ovf = 1'b1;
      cnt = cnt + (acc ? 1 : 0) - ((k == 1) ? 1 : 0);
    end
    @(negedge clk);
    bus.valid = 1'b0;
    chk({tag, "_count_end"}, fcount, cnt);
    chk({tag, "_ovf_end"}, ovf, model_ovf);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_drain_timeout"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_rx(input int base, input string tag);
    chk({tag, "_frames"}, rx_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[base + i], exp_q[i]);
    end
    chk({tag, "_framing_errors"}, rx_bad, 0);
  endtask

  initial begin : stimulus
    int base;
    int gap;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", bus.ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", fcount, 0);
    chk("post_rst_ovf", ovf, 0);
    chk("post_rst_ready", bus.ready, 1);

    // Single 0x55 frame with exact latency and bit timing.
    base = rx_q.size();
    check_frame(8'h55, "single55");
    chk("single55_rx", rx_q.size() - base, 1);

    // Burst of eight bytes ending in 0x03.
    exp_q.delete();
    base = rx_q.size();
    for (int k = 0; k < 8; k++) burst[k] = 8'h00;
    burst[7] = 8'h03;
    push_burst(8, "burst8");
    chk("burst8_peak", fcount, 7);
    wait_idle(2000, "burst8");
    compare_rx(base, "burst8");

    // Twenty random pushes: fills the buffer, drops the tail, sets overflow.
    exp_q.delete();
    base = rx_q.size();
    for (int k = 0; k < 20; k++) burst[k] = 8'($urandom);
    push_burst(20, "fill20");
    chk("fill20_ready_low", bus.ready, 0);
    chk("fill20_count_full", fcount, DEPTH);
    wait_idle(4000, "fill20");
    compare_rx(base, "fill20");
    chk("fill20_ovf_sticky", ovf, 1);

    // Reset in the middle of the data bits of 0xA3 with bytes still queued.
    exp_q.delete();
    burst[0] = 8'hA3;
    for (int k = 1; k < 4; k++) burst[k] = 8'($urandom);
    push_burst(4, "abort");
    repeat (43) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    rst_n = 1'b0;
    model_ovf = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_count", fcount, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = rx_q.size();
    check_frame(8'h0F, "after_rst0F");
    chk("after_rst_frames", rx_q.size() - base, 1);
    if (rx_q.size() > base) chk("after_rst_byte", rx_q[base], 8'h0F);

`ifdef UART_TX_PARITY_EN
    check_frame(8'h07, "par07");
    check_frame(8'h03, "par03");
`endif

    // Randomly spaced single pushes, never enough to fill the buffer.
    exp_q.delete();
    base = rx_q.size();
    for (int r = 0; r < 10; r++) begin
      gap = int'($urandom_range(0, 150));
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.valid = 1'b1;
      bus.data  = 8'($urandom);
      exp_q.push_back(bus.data);
      @(negedge clk);
      bus.valid = 1'b0;
    end
    wait_idle(3000, "rand");
    compare_rx(base, "rand");
    chk("rand_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
